// File: rtl/jogo_pkg.sv
// Shared definitions for the game datapath: cell and winner encodings,
// the line-to-cell table scanned by the board checker, FSM states and
// the default address of the macro-state board.
package jogo_pkg;

  // Cell contents as stored in the board memory
  localparam logic [1:0] CEL_VAZIA   = 2'b00;
  localparam logic [1:0] CEL_X       = 2'b01;
  localparam logic [1:0] CEL_O       = 2'b10;
  localparam logic [1:0] CEL_FECHADA = 2'b11;

  // Result codes reported on vencedor
  localparam logic [1:0] VENC_NENHUM = 2'b00;
  localparam logic [1:0] VENC_X      = 2'b01;
  localparam logic [1:0] VENC_O      = 2'b10;
  localparam logic [1:0] VENC_EMPATE = 2'b11;

  // Macro-state board sits right after the nine 9-cell micro boards
  localparam int BASE_MACRO_PADRAO = 81;

  // Evaluation order: rows, then columns, then the two diagonals.
  // The first winning line in this order decides the result.
  localparam logic [3:0] LINHA_CELULA [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    OCIOSO = 3'd0,
    LE     = 3'd1,
    ESPERA = 3'd2,
    AVALIA = 3'd3,
    FIM    = 3'd4
  } estado_t;

endpackage

// File: rtl/avaliador_linha.sv
// Combinational check of one 3-cell line. A line wins only when all three
// cells hold the same player mark; closed cells (11) never form a line.
module avaliador_linha
  import jogo_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  output logic       vence,
  output logic [1:0] jogador
);

  assign vence   = (a == b) && (b == c) && ((a == CEL_X) || (a == CEL_O));
  assign jogador = a;

endmodule

// File: rtl/verificador_tabuleiro.sv
// Board checker: reads the nine cells of one micro board (indice 0-8) or of
// the macro-state board (indice 9) from a synchronous memory, then scans the
// eight lines one per cycle and reports X win, O win, draw or open.
// Optional feature macro: VERIF_EMPATE_EN enables draw detection (full board
// with no winning line reports 11); without it that case reports 00.
module verificador_tabuleiro
  import jogo_pkg::*;
#(
  parameter int LATENCIA_MEM = 1,
  parameter int BASE_MACRO   = BASE_MACRO_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] indice_tabuleiro,
  input  logic [1:0] mem_dado,
  output logic       mem_le,
  output logic [6:0] mem_endereco,
  output logic       ocupado,
  output logic       pronto,
  output logic [1:0] vencedor
);

  estado_t     estado;
  logic [3:0]  cnt;
  logic [6:0]  base;
  logic [6:0]  base_sel;
  logic [1:0]  celulas [9];

  // Read-return tracking: stage s holds the request issued s+1 cycles ago
  logic        vld_p [LATENCIA_MEM];
  logic [3:0]  idx_p [LATENCIA_MEM];

  logic [1:0]  cel_a, cel_b, cel_c;
  logic        vence;
  logic [1:0]  jogador;
  logic [1:0]  fim_sem_linha;

  assign base_sel = (indice_tabuleiro == 4'd9) ? 7'(BASE_MACRO)
                                               : 7'(indice_tabuleiro) * 7'd9;

  assign ocupado = (estado != OCIOSO);
  assign pronto  = (estado == FIM);

  // Select the three cells of the line currently addressed by cnt
  always_comb begin
    cel_a = celulas[LINHA_CELULA[cnt[2:0]][0]];
    cel_b = celulas[LINHA_CELULA[cnt[2:0]][1]];
    cel_c = celulas[LINHA_CELULA[cnt[2:0]][2]];
  end

  avaliador_linha u_avaliador (
    .a       (cel_a),
    .b       (cel_b),
    .c       (cel_c),
    .vence   (vence),
    .jogador (jogador)
  );

`ifdef VERIF_EMPATE_EN
  logic cheio;

  // Board is full when no cell is empty; closed cells count as occupied
  always_comb begin
    cheio = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (celulas[i] == CEL_VAZIA) cheio = 1'b0;
    end
  end

  assign fim_sem_linha = cheio ? VENC_EMPATE : VENC_NENHUM;
`else
  assign fim_sem_linha = VENC_NENHUM;
`endif

  // Sequencer: accept, issue nine reads, wait out latency, scan lines
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      cnt          <= 4'd0;
      base         <= 7'd0;
      mem_le       <= 1'b0;
      mem_endereco <= 7'd0;
      vencedor     <= VENC_NENHUM;
    end else begin
      case (estado)
        OCIOSO: begin
          if (iniciar) begin
            cnt      <= 4'd0;
            vencedor <= VENC_NENHUM;
            if (indice_tabuleiro <= 4'd9) begin
              base         <= base_sel;
              mem_le       <= 1'b1;
              mem_endereco <= base_sel;
              estado       <= LE;
            end else begin
              estado <= FIM;
            end
          end
        end
        LE: begin
          if (cnt == 4'd8) begin
            mem_le <= 1'b0;
            cnt    <= 4'd0;
            estado <= ESPERA;
          end else begin
            cnt          <= cnt + 4'd1;
            mem_endereco <= base + 7'(cnt) + 7'd1;
          end
        end
        ESPERA: begin
          if (cnt == 4'(LATENCIA_MEM - 1)) begin
            cnt    <= 4'd0;
            estado <= AVALIA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        AVALIA: begin
          if (vence) begin
            vencedor <= jogador;
            estado   <= FIM;
          end else if (cnt == 4'd7) begin
            vencedor <= fim_sem_linha;
            estado   <= FIM;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        FIM:     estado <= OCIOSO;
        default: estado <= OCIOSO;
      endcase
    end
  end

  // Track outstanding reads and write returning data into the cell file
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < LATENCIA_MEM; s++) begin
        vld_p[s] <= 1'b0;
        idx_p[s] <= 4'd0;
      end
      for (int i = 0; i < 9; i++) celulas[i] <= CEL_VAZIA;
    end else begin
      vld_p[0] <= mem_le;
      idx_p[0] <= cnt;
      for (int s = 1; s < LATENCIA_MEM; s++) begin
        vld_p[s] <= vld_p[s-1];
        idx_p[s] <= idx_p[s-1];
      end
      if ((estado == OCIOSO) && iniciar) begin
        for (int i = 0; i < 9; i++) celulas[i] <= CEL_VAZIA;
      end else if (vld_p[LATENCIA_MEM-1]) begin
        celulas[idx_p[LATENCIA_MEM-1]] <= mem_dado;
      end
    end
  end

endmodule

// File: tb/tb_verificador_tabuleiro.sv
// Directed bench for verificador_tabuleiro: one instance with read latency 1
// and one with latency 2, sharing a behavioural board memory.
module tb_verificador_tabuleiro;

  localparam logic [1:0] V = 2'b00;
  localparam logic [1:0] X = 2'b01;
  localparam logic [1:0] O = 2'b10;
  localparam logic [1:0] F = 2'b11;
`ifdef VERIF_EMPATE_EN
  localparam logic [1:0] EMP = 2'b11;
`else
  localparam logic [1:0] EMP = 2'b00;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar1, iniciar2;
  logic [3:0] indice;
  logic [1:0] mem_dado1, mem_dado2;
  logic       mem_le1, mem_le2;
  logic [6:0] mem_endereco1, mem_endereco2;
  logic       ocupado1, ocupado2;
  logic       pronto1, pronto2;
  logic [1:0] vencedor1, vencedor2;

  always #5 clock = ~clock;

  verificador_tabuleiro #(.LATENCIA_MEM(1), .BASE_MACRO(81)) dut1 (
    .clock(clock), .reset(reset), .iniciar(iniciar1), .indice_tabuleiro(indice),
    .mem_dado(mem_dado1), .mem_le(mem_le1), .mem_endereco(mem_endereco1),
    .ocupado(ocupado1), .pronto(pronto1), .vencedor(vencedor1));

  verificador_tabuleiro #(.LATENCIA_MEM(2), .BASE_MACRO(81)) dut2 (
    .clock(clock), .reset(reset), .iniciar(iniciar2), .indice_tabuleiro(indice),
    .mem_dado(mem_dado2), .mem_le(mem_le2), .mem_endereco(mem_endereco2),
    .ocupado(ocupado2), .pronto(pronto2), .vencedor(vencedor2));

  // Board memory with synchronous read, latency 1 and 2 ports
  logic [1:0] mem [0:127];
  logic [1:0] rd1_p1, rd2_p1, rd2_p2;
  always_ff @(posedge clock) begin
    if (mem_le1) rd1_p1 <= mem[mem_endereco1];
    if (mem_le2) rd2_p1 <= mem[mem_endereco2];
    rd2_p2 <= rd2_p1;
  end
  assign mem_dado1 = rd1_p1;
  assign mem_dado2 = rd2_p2;

  // Observed outputs of the instance under test
  int sel = 0;
  logic       le_s, oc_s, pr_s;
  logic [6:0] ad_s;
  logic [1:0] ve_s;
  assign le_s = (sel == 0) ? mem_le1       : mem_le2;
  assign ad_s = (sel == 0) ? mem_endereco1 : mem_endereco2;
  assign oc_s = (sel == 0) ? ocupado1      : ocupado2;
  assign pr_s = (sel == 0) ? pronto1       : pronto2;
  assign ve_s = (sel == 0) ? vencedor1     : vencedor2;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nome, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
  endtask

  function automatic logic [17:0] tab(input logic [1:0] c0, c1, c2, c3, c4,
                                      c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  task automatic carrega(input logic [3:0] ind, input logic [17:0] cel);
    int b;
    b = (ind == 4'd9) ? 81 : int'(ind) * 9;
    for (int i = 0; i < 9; i++) mem[b + i] = cel[2*i +: 2];
  endtask

  // One scan: accept, follow the addresses, find pronto and check the result
  task automatic scan(input int s, input logic [3:0] ind, input int pulse_at,
                      input int reset_at, input int exp_pronto,
                      input logic [1:0] exp_venc, input string nome);
    int   b, bad, got_pronto;
    logic [1:0] got_venc;
    bit   rst_feito;
    sel = s;
    b = (ind == 4'd9) ? 81 : int'(ind) * 9;
    @(negedge clock);
    indice = ind;
    if (s == 0) iniciar1 = 1'b1; else iniciar2 = 1'b1;
    @(posedge clock);
    #1;
    iniciar1 = 1'b0;
    iniciar2 = 1'b0;
    indice = 4'd5;
    bad = 0; got_pronto = -1; got_venc = 2'b00; rst_feito = 1'b0;
    for (int c = 0; c < 40 && got_pronto < 0; c++) begin
      @(negedge clock);
      iniciar1 = 1'b0;
      iniciar2 = 1'b0;
      if (c == pulse_at) begin
        indice = 4'd9;
        if (s == 0) iniciar1 = 1'b1; else iniciar2 = 1'b1;
      end
      if (!rst_feito) begin
        if (!oc_s) bad++;
        if (ind <= 4'd9 && c < 9) begin
          if (!le_s || int'(ad_s) != b + c) bad++;
        end else if (le_s) begin
          bad++;
        end
      end
      if (pr_s) begin
        got_pronto = c;
        got_venc   = ve_s;
      end
      if (c == reset_at) begin
        reset = 1'b0;
        #1;
        chk({nome, " reset outputs"}, int'({le_s, ad_s, oc_s, pr_s, ve_s}), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        rst_feito = 1'b1;
      end
    end
    chk({nome, " address/ocupado errors"}, bad, 0);
    chk({nome, " pronto cycle"}, got_pronto, exp_pronto);
    if (exp_pronto >= 0) begin
      chk({nome, " vencedor"}, int'(got_venc), int'(exp_venc));
      @(negedge clock);
      chk({nome, " idle after pronto {ocupado,pronto,vencedor}"},
          int'({oc_s, pr_s, ve_s}), int'({2'b00, exp_venc}));
    end
  endtask

  typedef struct {
    logic [3:0]  ind;
    logic [17:0] cel;
    int          exp_pronto;
    logic [1:0]  exp_venc;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{4'd4,  tab(X,X,X, V,V,V, V,V,V), 11, X};
    vecs[1] = '{4'd9,  tab(V,V,O, V,O,V, O,V,V), 18, O};
    vecs[2] = '{4'd0,  tab(X,O,X, X,O,O, O,X,X), 18, EMP};
    vecs[3] = '{4'd9,  tab(F,F,F, F,F,F, F,F,F), 18, EMP};
    vecs[4] = '{4'd12, tab(V,V,V, V,V,V, V,V,V),  0, 2'b00};
    vecs[5] = '{4'd8,  tab(V,O,V, V,O,V, V,O,V), 15, O};
    vecs[6] = '{4'd2,  tab(X,V,V, V,X,V, V,V,X), 17, X};
    vecs[7] = '{4'd1,  tab(X,V,V, V,O,V, V,V,V), 18, 2'b00};
    vecs[8] = '{4'd3,  tab(O,O,O, V,V,V, X,X,X), 11, O};
    vecs[9] = '{4'd5,  tab(F,V,X, V,V,X, F,V,X), 16, X};

    for (int i = 0; i < 128; i++) mem[i] = 2'b00;
    reset = 1'b0;
    iniciar1 = 1'b0;
    iniciar2 = 1'b0;
    indice = 4'd0;
    repeat (3) @(negedge clock);
    chk("reset state dut1", int'({mem_le1, mem_endereco1, ocupado1, pronto1, vencedor1}), 0);
    chk("reset state dut2", int'({mem_le2, mem_endereco2, ocupado2, pronto2, vencedor2}), 0);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].ind <= 4'd9) carrega(vecs[i].ind, vecs[i].cel);
      scan(0, vecs[i].ind, -1, -1, vecs[i].exp_pronto, vecs[i].exp_venc,
           $sformatf("vec%0d", i));
    end

    // Start request during LE must be ignored (macro board would give no win)
    carrega(4'd4, tab(X,X,X, V,V,V, V,V,V));
    carrega(4'd9, tab(F,F,F, F,F,F, F,F,F));
    scan(0, 4'd4, 3, -1, 11, X, "iniciar during LE");

    // Latency 2: reset in cycle 5, then a fresh row-0 win
    carrega(4'd6, tab(X,X,X, V,V,V, V,V,V));
    scan(1, 4'd6, -1, 5, -1, 2'b00, "L2 reset mid-scan");
    scan(1, 4'd6, -1, -1, 12, X, "L2 after reset");
    carrega(4'd9, tab(V,V,O, V,O,V, O,V,V));
    scan(1, 4'd9, -1, -1, 19, O, "L2 macro anti-diagonal");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/verificador_tabuleiro.md
# verificador_tabuleiro

Sequencer that scans one 3x3 board of the game's board memory and reports its result: X wins, O wins, draw or still open. It sits in the game datapath next to the board memory and is started by the game control unit after each accepted move. It evaluates either one of the nine micro boards or the macro-state board. It drives the memory read port while busy and raises a one-cycle `pronto` with a registered `vencedor`.

## Interface
- `LATENCIA_MEM`, default 1: synchronous read latency of the board memory in cycles; legal values are 1 and 2.
- `BASE_MACRO`, default 81: base address of the 9-cell macro-state board.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; `reset`=0 forces every register to its reset value immediately.
- `iniciar` input 1: start request, sampled only in OCIOSO.
- `indice_tabuleiro` input 4: 0–8 selects micro board `indice`; 9 selects the macro board; 10–15 are invalid.
- `mem_dado` input 2: cell contents: 00 empty, 01 X, 10 O, 11 closed/draw (macro board only).
- `mem_le` output 1: memory read enable.
- `mem_endereco` output 7: cell address.
- `ocupado` output 1: high in every state except OCIOSO.
- `pronto` output 1: one-cycle completion pulse.
- `vencedor` output 2: 00 none, 01 X, 10 O, 11 draw.

## Operation
- States: OCIOSO, LE, ESPERA, AVALIA, FIM.
- OCIOSO:
  - `iniciar`=1 latches `indice_tabuleiro` into a base register, clears the 9x2 cell file and line counter, and enters LE.
  - An invalid index (10–15) goes straight to FIM with `vencedor`=00 and performs no reads.
- Addressing:
  - Micro board: base = `indice`*9.
  - Macro board: base = `BASE_MACRO`.
- LE: 9 cycles. Cycle i (i=0..8) drives `mem_le`=1 and `mem_endereco`=base+i.
- ESPERA: `LATENCIA_MEM` cycles with `mem_le`=0.
- Capture: `mem_dado` for cell i is captured into cell file entry i exactly `LATENCIA_MEM` cycles after its address.
- AVALIA: one line per cycle, in fixed order:
  - lines 0–2: rows {0,1,2}, {3,4,5}, {6,7,8};
  - lines 3–5: columns {0,3,6}, {1,4,7}, {2,5,8};
  - line 6: {0,4,8}; line 7: {2,4,6}.
- Line win: all three cells equal and equal to 01 or 10. Value 11 never forms a winning line.
- First winning line in the order above ends AVALIA and goes to FIM with `vencedor` = that cell value. Later lines are not examined.
- After line 7 with no winner:
  - `vencedor`=11 if all 9 cells are nonzero (draw);
  - otherwise `vencedor`=00.
- FIM: one cycle, `pronto`=1, then OCIOSO.
- `vencedor` is registered, written on the edge entering FIM, and held until the next accepted `iniciar`. The accept edge clears it to 00.
- `iniciar` while `ocupado`=1 is ignored. `indice_tabuleiro` changes after acceptance are ignored.
- Reset mid-scan: immediate return to OCIOSO; no `pronto`; outputs take reset values.
- Reset values: `mem_le`=0, `mem_endereco`=0, `ocupado`=0, `pronto`=0, `vencedor`=00, state OCIOSO.

## Timing
- Let L = `LATENCIA_MEM`, and let cycle 0 be the first cycle after the edge that accepts `iniciar`.
- Address for cell i is driven in cycle i. Data is captured at the end of cycle i+L.
- AVALIA evaluates line k in cycle 9+L+k.
- Win on line k: `pronto` in cycle 10+L+k. For L=1 that is cycles 11–18.
- No win: `pronto` in cycle 17+L (cycle 18 for L=1).
- Invalid index: `pronto` in cycle 0 (one cycle after accept).
- `mem_endereco` holds its last value when `mem_le`=0.
- Back-to-back operation: the earliest new accept is the cycle after `pronto`.

## Configuration
- `VERIF_EMPATE_EN` defined: draw detection is present, with `vencedor`=11 for a full board with no winning line.
- `VERIF_EMPATE_EN` not defined: a full board with no line reports 00, and the all-nonzero check is not synthesized.

## Structure
- Shared package `jogo_pkg` holds:
  - cell encoding constants (VAZIA, X, O, FECHADA);
  - `vencedor` codes;
  - the 8x3 line-to-cell table;
  - the state enum;
  - the default `BASE_MACRO`.
- One sub-module, `avaliador_linha`: combinational; three 2-bit cells in, outputs `vence` and `jogador`.

## Test plan
- Micro board 4 with X on cells 0,1,2 (addresses 36–38), L=1 -> `mem_endereco` 36..44 in cycles 0..8; `pronto` in cycle 11; `vencedor`=01.
- Macro board (`indice`=9) with O on cells 2,4,6 only -> addresses 81..89; `pronto` in cycle 18; `vencedor`=10.
- Full board, no line, with `VERIF_EMPATE_EN` -> `vencedor`=11 at cycle 18; without the macro -> 00.
- Macro board with all cells 11 -> no win; draw 11 with `VERIF_EMPATE_EN`, confirming 11 never forms a line.
- `indice`=12 -> no `mem_le`; `pronto` in cycle 0; `vencedor`=00. Separately, `iniciar` pulsed during LE is ignored.
- `reset`=0 asserted in cycle 5 of a scan, L=2 -> all outputs zero asynchronously; no `pronto`; a fresh start afterwards behaves normally with `pronto` at cycle 12 for a row-0 win.
